// File: rtl/udp_echo_pkg.sv
// Shared types and constants for the UDP echo responder: FSM state encoding,
// UDP header length and the TX length helper.
package udp_echo_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RX_PAY = 3'd1,
        DROP   = 3'd2,
        TX_HDR = 3'd3,
        TX_PAY = 3'd4
    } state_t;

    localparam int UDP_HDR_LEN = 8;

    // The UDP length field counts the 8-byte header plus payload, wrapping at 16 bits.
    function automatic logic [15:0] udp_length(input logic [15:0] payload_bytes);
        return payload_bytes + 16'(UDP_HDR_LEN);
    endfunction

endpackage

// File: rtl/udp_echo_responder_if.sv
// Header + payload bundle between the UDP port filter, the echo responder and the TX UDP/IP stack.
// Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1; valid never waits on ready.
interface udp_echo_responder_if;

    logic        rx_udp_hdr_valid;
    logic        rx_udp_hdr_ready;
    logic [31:0] rx_ip_source_ip;
    logic [31:0] rx_ip_dest_ip;
    logic [15:0] rx_udp_source_port;
    logic [15:0] rx_udp_dest_port;

    logic [7:0]  rx_fifo_udp_payload_axis_tdata;
    logic        rx_fifo_udp_payload_axis_tvalid;
    logic        rx_fifo_udp_payload_axis_tready;
    logic        rx_fifo_udp_payload_axis_tlast;
    logic        rx_fifo_udp_payload_axis_tuser;

    logic        tx_udp_hdr_valid;
    logic        tx_udp_hdr_ready;
    logic [31:0] tx_ip_source_ip;
    logic [31:0] tx_ip_dest_ip;
    logic [15:0] tx_udp_source_port;
    logic [15:0] tx_udp_dest_port;
    logic [15:0] tx_udp_length;
    logic [7:0]  tx_ip_ttl;

    logic [7:0]  tx_udp_payload_axis_tdata;
    logic        tx_udp_payload_axis_tvalid;
    logic        tx_udp_payload_axis_tready;
    logic        tx_udp_payload_axis_tlast;
    logic        tx_udp_payload_axis_tuser;

    // Responder side: consumes RX, produces TX.
    modport slave (
        input  rx_udp_hdr_valid, rx_ip_source_ip, rx_ip_dest_ip,
               rx_udp_source_port, rx_udp_dest_port,
               rx_fifo_udp_payload_axis_tdata, rx_fifo_udp_payload_axis_tvalid,
               rx_fifo_udp_payload_axis_tlast, rx_fifo_udp_payload_axis_tuser,
               tx_udp_hdr_ready, tx_udp_payload_axis_tready,
        output rx_udp_hdr_ready, rx_fifo_udp_payload_axis_tready,
               tx_udp_hdr_valid, tx_ip_source_ip, tx_ip_dest_ip,
               tx_udp_source_port, tx_udp_dest_port, tx_udp_length, tx_ip_ttl,
               tx_udp_payload_axis_tdata, tx_udp_payload_axis_tvalid,
               tx_udp_payload_axis_tlast, tx_udp_payload_axis_tuser
    );

    // Environment side: produces RX, consumes TX.
    modport master (
        output rx_udp_hdr_valid, rx_ip_source_ip, rx_ip_dest_ip,
               rx_udp_source_port, rx_udp_dest_port,
               rx_fifo_udp_payload_axis_tdata, rx_fifo_udp_payload_axis_tvalid,
               rx_fifo_udp_payload_axis_tlast, rx_fifo_udp_payload_axis_tuser,
               tx_udp_hdr_ready, tx_udp_payload_axis_tready,
        input  rx_udp_hdr_ready, rx_fifo_udp_payload_axis_tready,
               tx_udp_hdr_valid, tx_ip_source_ip, tx_ip_dest_ip,
               tx_udp_source_port, tx_udp_dest_port, tx_udp_length, tx_ip_ttl,
               tx_udp_payload_axis_tdata, tx_udp_payload_axis_tvalid,
               tx_udp_payload_axis_tlast, tx_udp_payload_axis_tuser
    );

endinterface

// File: rtl/udp_echo_buffer.sv
// Payload store for one datagram: synchronous write, asynchronous read, so the
// echoed byte follows the read pointer in the same cycle.
module udp_echo_buffer #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/udp_echo_responder.sv
// Store-and-forward UDP echo: buffers one datagram, then replies with swapped
// addresses/ports and the same payload. Errored or oversized datagrams are dropped whole.
module udp_echo_responder
    import udp_echo_pkg::*;
#(
    parameter int DEPTH    = 2048,
    parameter int ECHO_TTL = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    udp_echo_responder_if.slave  bus,
    output logic [15:0]          echo_count,
    output logic [15:0]          drop_count,
    output state_t               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t      state;
    state_t      state_next;

    logic [31:0] hdr_src_ip;
    logic [31:0] hdr_dst_ip;
    logic [15:0] hdr_src_port;
    logic [15:0] hdr_dst_port;
    logic [CW-1:0] byte_count;
    logic [CW-1:0] rd_ptr;

    logic hdr_ready_c;
    logic pay_ready_c;
    logic hdr_valid_c;
    logic tx_valid_c;
    logic tx_last;
    logic capture;
    logic wr_en;
    logic drop_inc;
    logic echo_inc;
    logic rd_clear;
    logic rd_inc;
    logic [7:0] rd_data;

    assign tx_last = (state == TX_PAY) && (rd_ptr == byte_count - CW'(1));

    always_comb begin
        state_next  = state;
        hdr_ready_c = 1'b0;
        pay_ready_c = 1'b0;
        hdr_valid_c = 1'b0;
        tx_valid_c  = 1'b0;
        capture     = 1'b0;
        wr_en       = 1'b0;
        drop_inc    = 1'b0;
        echo_inc    = 1'b0;
        rd_clear    = 1'b0;
        rd_inc      = 1'b0;
        case (state)
            IDLE: begin
                hdr_ready_c = 1'b1;
                if (bus.rx_udp_hdr_valid) begin
                    capture    = 1'b1;
                    state_next = RX_PAY;
                end
            end
            RX_PAY: begin
                pay_ready_c = 1'b1;
                if (bus.rx_fifo_udp_payload_axis_tvalid) begin
                    // A beat arriving with the buffer already full marks the datagram as too long.
                    if (byte_count == CW'(DEPTH)) begin
                        if (bus.rx_fifo_udp_payload_axis_tlast) begin
                            drop_inc   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = DROP;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (bus.rx_fifo_udp_payload_axis_tlast) begin
                            if (bus.rx_fifo_udp_payload_axis_tuser) begin
                                drop_inc   = 1'b1;
                                state_next = IDLE;
                            end else begin
                                state_next = TX_HDR;
                            end
                        end
                    end
                end
            end
            DROP: begin
                pay_ready_c = 1'b1;
                if (bus.rx_fifo_udp_payload_axis_tvalid && bus.rx_fifo_udp_payload_axis_tlast) begin
                    drop_inc   = 1'b1;
                    state_next = IDLE;
                end
            end
            TX_HDR: begin
                hdr_valid_c = 1'b1;
                if (bus.tx_udp_hdr_ready) begin
                    rd_clear   = 1'b1;
                    state_next = TX_PAY;
                end
            end
            TX_PAY: begin
                tx_valid_c = 1'b1;
                if (bus.tx_udp_payload_axis_tready) begin
                    rd_inc = 1'b1;
                    if (tx_last) begin
                        echo_inc   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            hdr_src_ip   <= '0;
            hdr_dst_ip   <= '0;
            hdr_src_port <= '0;
            hdr_dst_port <= '0;
            byte_count   <= '0;
            rd_ptr       <= '0;
            echo_count   <= '0;
            drop_count   <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                hdr_src_ip   <= bus.rx_ip_source_ip;
                hdr_dst_ip   <= bus.rx_ip_dest_ip;
                hdr_src_port <= bus.rx_udp_source_port;
                hdr_dst_port <= bus.rx_udp_dest_port;
                byte_count   <= '0;
            end else if (wr_en) begin
                byte_count <= byte_count + CW'(1);
            end
            if (rd_clear) begin
                rd_ptr <= '0;
            end else if (rd_inc) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            if (drop_inc) begin
                drop_count <= drop_count + 16'd1;
            end
            if (echo_inc) begin
                echo_count <= echo_count + 16'd1;
            end
        end
    end

    udp_echo_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (byte_count[AW-1:0]),
        .wr_data (bus.rx_fifo_udp_payload_axis_tdata),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (rd_data)
    );

    // IDLE is the reset state, but nothing may be accepted while reset is held.
    assign bus.rx_udp_hdr_ready                = hdr_ready_c & reset;
    assign bus.rx_fifo_udp_payload_axis_tready = pay_ready_c;

    assign bus.tx_udp_hdr_valid   = hdr_valid_c;
    assign bus.tx_ip_source_ip    = hdr_dst_ip;
    assign bus.tx_ip_dest_ip      = hdr_src_ip;
    assign bus.tx_udp_source_port = hdr_dst_port;
    assign bus.tx_udp_dest_port   = hdr_src_port;
    assign bus.tx_udp_length      = udp_length(16'(byte_count));
    assign bus.tx_ip_ttl          = 8'(ECHO_TTL);

    assign bus.tx_udp_payload_axis_tdata  = rd_data;
    assign bus.tx_udp_payload_axis_tvalid = tx_valid_c;
    assign bus.tx_udp_payload_axis_tlast  = tx_last;
    assign bus.tx_udp_payload_axis_tuser  = 1'b0;

    assign dbg_state = state;

endmodule

// File: tb/tb_udp_echo_responder.sv
// Bench for udp_echo_responder at DEPTH=16: vector table of datagrams plus
// hand-written back-pressure, back-to-back and mid-echo reset sequences.
module tb_udp_echo_responder;
    import udp_echo_pkg::*;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    udp_echo_responder_if bus();
    logic [15:0] echo_count;
    logic [15:0] drop_count;
    state_t      dbg_state;

    udp_echo_responder #(.DEPTH(16), .ECHO_TTL(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .echo_count (echo_count),
        .drop_count (drop_count),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [111:0] exp_hdr_q[$];
    logic [8:0]   exp_q[$];

    task automatic chk(input string name, input logic [111:0] act, input logic [111:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- TX sink readies ----------------
    int       hdr_stall_cfg = 0;
    bit [3:0] tr_pat = 4'b1111;
    int       hdr_hold = 0;
    int       pidx = 0;
    logic     prev_hv = 1'b0;

    always @(posedge clock) begin
        #1;
        if (bus.tx_udp_hdr_valid === 1'b1 && !prev_hv) hdr_hold = hdr_stall_cfg;
        prev_hv = (bus.tx_udp_hdr_valid === 1'b1);
        bus.tx_udp_hdr_ready = (hdr_hold == 0);
        if (hdr_hold > 0) hdr_hold--;
        if (bus.tx_udp_payload_axis_tvalid === 1'b1) begin
            bus.tx_udp_payload_axis_tready = tr_pat[pidx % 4];
            pidx++;
        end else begin
            bus.tx_udp_payload_axis_tready = 1'b1;
        end
    end

    // ---------------- TX monitor ----------------
    int           hv_cycles = 0;
    int           tlast_cyc = 0;
    logic [111:0] cur_hdr, prev_hdr;
    logic [8:0]   cur_beat, prev_beat;
    logic         prev_hstall = 1'b0, prev_pstall = 1'b0, prev_hshake = 1'b0;

    always @(negedge clock) begin
        if (reset) begin
            cur_hdr  = {bus.tx_ip_source_ip, bus.tx_ip_dest_ip, bus.tx_udp_source_port,
                        bus.tx_udp_dest_port, bus.tx_udp_length};
            cur_beat = {bus.tx_udp_payload_axis_tlast, bus.tx_udp_payload_axis_tdata};
            if (prev_hstall) chk("hdr_stable_while_stalled", {bus.tx_udp_hdr_valid, cur_hdr}, {1'b1, prev_hdr});
            if (prev_pstall) chk("beat_stable_while_stalled", {bus.tx_udp_payload_axis_tvalid, cur_beat}, {1'b1, prev_beat});
            if (prev_hshake) chk("first_beat_latency", bus.tx_udp_payload_axis_tvalid, 1'b1);
            if (bus.tx_udp_hdr_valid || bus.tx_udp_payload_axis_tvalid)
                chk("rx_backpressure", {bus.rx_udp_hdr_ready, bus.rx_fifo_udp_payload_axis_tready}, 2'b00);
            if (bus.tx_udp_hdr_valid) hv_cycles++;
            if (bus.tx_udp_hdr_valid && bus.tx_udp_hdr_ready) begin
                chk("tx_hdr_expected", exp_hdr_q.size() != 0, 1'b1);
                if (exp_hdr_q.size() != 0) chk("tx_hdr", cur_hdr, exp_hdr_q.pop_front());
                chk("tx_ttl", bus.tx_ip_ttl, 8'd64);
            end
            if (bus.tx_udp_payload_axis_tvalid && bus.tx_udp_payload_axis_tready) begin
                chk("tx_beat_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("tx_beat", cur_beat, exp_q.pop_front());
                chk("tx_tuser", bus.tx_udp_payload_axis_tuser, 1'b0);
                if (bus.tx_udp_payload_axis_tlast) tlast_cyc = cyc;
            end
            prev_hstall = bus.tx_udp_hdr_valid && !bus.tx_udp_hdr_ready;
            prev_pstall = bus.tx_udp_payload_axis_tvalid && !bus.tx_udp_payload_axis_tready;
            prev_hshake = bus.tx_udp_hdr_valid && bus.tx_udp_hdr_ready;
            prev_hdr    = cur_hdr;
            prev_beat   = cur_beat;
        end else begin
            prev_hstall = 1'b0;
            prev_pstall = 1'b0;
            prev_hshake = 1'b0;
        end
    end

    // ---------------- RX driver tasks ----------------
    logic [7:0] pay [0:31];

    task automatic send_hdr(input logic [31:0] sip, input logic [31:0] dip,
                            input logic [15:0] sp, input logic [15:0] dp, output int acc_cyc);
        bit ok = 0;
        acc_cyc = 0;
        bus.rx_ip_source_ip    = sip;
        bus.rx_ip_dest_ip      = dip;
        bus.rx_udp_source_port = sp;
        bus.rx_udp_dest_port   = dp;
        bus.rx_udp_hdr_valid   = 1'b1;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clock);
            if (bus.rx_udp_hdr_ready) begin
                ok = 1;
                acc_cyc = cyc;
            end
        end
        @(posedge clock); #1;
        bus.rx_udp_hdr_valid = 1'b0;
        chk("rx_hdr_accepted", ok, 1'b1);
    endtask

    task automatic send_payload(input int len, input logic tuser, output int accepted);
        bit ok;
        accepted = 0;
        for (int i = 0; i < len; i++) begin
            ok = 0;
            bus.rx_fifo_udp_payload_axis_tdata  = pay[i];
            bus.rx_fifo_udp_payload_axis_tlast  = (i == len - 1);
            bus.rx_fifo_udp_payload_axis_tuser  = tuser && (i == len - 1);
            bus.rx_fifo_udp_payload_axis_tvalid = 1'b1;
            for (int k = 0; k < 300 && !ok; k++) begin
                @(negedge clock);
                if (bus.rx_fifo_udp_payload_axis_tready) ok = 1;
            end
            @(posedge clock); #1;
            if (!ok) break;
            accepted++;
        end
        bus.rx_fifo_udp_payload_axis_tvalid = 1'b0;
        bus.rx_fifo_udp_payload_axis_tlast  = 1'b0;
        bus.rx_fifo_udp_payload_axis_tuser  = 1'b0;
    endtask

    task automatic push_expect(input logic [31:0] sip, input logic [31:0] dip,
                               input logic [15:0] sp, input logic [15:0] dp, input int len, input int nbytes);
        exp_hdr_q.push_back({dip, sip, dp, sp, 16'(len + 8)});
        for (int i = 0; i < nbytes; i++) exp_q.push_back({(i == len - 1), pay[i]});
    endtask

    task automatic send_frame(input logic [31:0] sip, input logic [31:0] dip,
                              input logic [15:0] sp, input logic [15:0] dp,
                              input int len, input logic tuser, input logic echo);
        int acc, a_cyc;
        if (echo) push_expect(sip, dip, sp, dp, len, len);
        send_hdr(sip, dip, sp, dp, a_cyc);
        send_payload(len, tuser, acc);
        chk("rx_beats_accepted", acc, len);
        @(negedge clock);
        chk("tx_hdr_latency", bus.tx_udp_hdr_valid, echo);
        @(posedge clock); #1;
    endtask

    task automatic wait_drain();
        bit done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clock);
            if (exp_q.size() == 0 && exp_hdr_q.size() == 0 && bus.rx_udp_hdr_ready) done = 1;
        end
        @(posedge clock); #1;
        chk("drain_to_idle", done, 1'b1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int   len;
        logic tuser;
        logic echo;
    } vec_t;
    vec_t vt [9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sip, dip;
        logic [15:0] sp, dp;
        int exp_echo, exp_drop, acc, a_cyc;

        bus.rx_udp_hdr_valid = 1'b0;
        bus.rx_ip_source_ip = '0;
        bus.rx_ip_dest_ip = '0;
        bus.rx_udp_source_port = '0;
        bus.rx_udp_dest_port = '0;
        bus.rx_fifo_udp_payload_axis_tdata = '0;
        bus.rx_fifo_udp_payload_axis_tvalid = 1'b0;
        bus.rx_fifo_udp_payload_axis_tlast = 1'b0;
        bus.rx_fifo_udp_payload_axis_tuser = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_hdr_ready", bus.rx_udp_hdr_ready, 1'b0);
        chk("reset_pay_ready", bus.rx_fifo_udp_payload_axis_tready, 1'b0);
        chk("reset_tx_valids", {bus.tx_udp_hdr_valid, bus.tx_udp_payload_axis_tvalid}, 2'b00);
        chk("reset_counters", {echo_count, drop_count}, 32'h0);
        chk("reset_state", dbg_state, IDLE);
        chk("reset_length", bus.tx_udp_length, 16'd8);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("idle_hdr_ready", bus.rx_udp_hdr_ready, 1'b1);
        chk("idle_pay_ready", bus.rx_fifo_udp_payload_axis_tready, 1'b0);

        vt[0] = '{4,  1'b0, 1'b1};
        vt[1] = '{6,  1'b1, 1'b0};
        vt[2] = '{5,  1'b0, 1'b1};
        vt[3] = '{20, 1'b0, 1'b0};
        vt[4] = '{16, 1'b0, 1'b1};
        vt[5] = '{17, 1'b0, 1'b0};
        vt[6] = '{1,  1'b0, 1'b1};
        vt[7] = '{16, 1'b1, 1'b0};
        vt[8] = '{2,  1'b0, 1'b1};

        exp_echo = 0;
        exp_drop = 0;
        for (int v = 0; v < 9; v++) begin
            if (v == 0) begin
                sip = 32'h0A00_0002; sp = 16'd5000;
                dip = 32'h0A00_0001; dp = 16'd1234;
            end else begin
                sip = $urandom; dip = $urandom;
                sp = 16'($urandom_range(1, 65535)); dp = 16'($urandom_range(1, 65535));
            end
            for (int i = 0; i < vt[v].len; i++)
                pay[i] = (v == 0) ? 8'(i + 1) : 8'($urandom_range(0, 255));
            send_frame(sip, dip, sp, dp, vt[v].len, vt[v].tuser, vt[v].echo);
            wait_drain();
            if (vt[v].echo) exp_echo++; else exp_drop++;
            chk("echo_count", echo_count, 16'(exp_echo));
            chk("drop_count", drop_count, 16'(exp_drop));
        end

        // Header held off 5 cycles, payload ready pattern 1,0,0,1.
        hdr_stall_cfg = 5;
        tr_pat = 4'b1001;
        hv_cycles = 0;
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom_range(0, 255));
        send_frame(32'hC0A8_0105, 32'hC0A8_0101, 16'd4000, 16'd1234, 8, 1'b0, 1'b1);
        wait_drain();
        exp_echo++;
        chk("hdr_stall_cycles", hv_cycles, 6);
        chk("echo_count_bp", echo_count, 16'(exp_echo));
        tr_pat = 4'b1111;

        // 1-byte datagram with a second header queued right behind it.
        hdr_stall_cfg = 3;
        pay[0] = 8'h5A;
        send_frame(32'h0A00_0009, 32'h0A00_0001, 16'd7777, 16'd1234, 1, 1'b0, 1'b1);
        send_hdr(32'h0A00_000A, 32'h0A00_0001, 16'd8888, 16'd1234, a_cyc);
        chk("b2b_hdr_after_tlast", {a_cyc > tlast_cyc, exp_q.size() == 0}, 2'b11);
        pay[0] = 8'hA1; pay[1] = 8'hB2; pay[2] = 8'hC3;
        push_expect(32'h0A00_000A, 32'h0A00_0001, 16'd8888, 16'd1234, 3, 3);
        send_payload(3, 1'b0, acc);
        chk("b2b_beats_accepted", acc, 3);
        wait_drain();
        exp_echo += 2;
        chk("echo_count_b2b", echo_count, 16'(exp_echo));
        hdr_stall_cfg = 0;

        // Reset after two of eight echoed bytes.
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom_range(0, 255));
        push_expect(32'h0A00_0002, 32'h0A00_0001, 16'd5000, 16'd1234, 8, 2);
        send_hdr(32'h0A00_0002, 32'h0A00_0001, 16'd5000, 16'd1234, a_cyc);
        send_payload(8, 1'b0, acc);
        for (int k = 0; k < 200; k++) begin
            @(negedge clock); #1;
            if (exp_q.size() == 0 && exp_hdr_q.size() == 0) break;
        end
        chk("rst_two_bytes_echoed", exp_q.size() + exp_hdr_q.size(), 0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        chk("rst_tvalid_drop", bus.tx_udp_payload_axis_tvalid, 1'b0);
        chk("rst_counters", {echo_count, drop_count}, 32'h0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_release_idle", {dbg_state, bus.rx_udp_hdr_ready}, {IDLE, 1'b1});
        repeat (12) @(negedge clock);
        chk("rst_no_partial_output", {bus.tx_udp_hdr_valid, bus.tx_udp_payload_axis_tvalid}, 2'b00);
        chk("rst_counters_after", {echo_count, drop_count}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
